ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the keyboard over the same kclk/kdata lines the keyboard receive path listens on. The block drives the lines through open-drain "drive low" enables at the top-level pads, generates the request-to-send sequence, and shifts data, odd parity and stop bits on device-generated clocks. It then checks the device acknowledge and reports done or error. While `busy` is high, the receive path must ignore line activity.

---
 rtl/ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the device over
// the shared kclk/kdata lines using open-drain "drive low" enables. The block
// issues the request-to-send sequence (clock inhibit, then data low), shifts
// the byte LSB first, then odd parity and the stop bit on device-generated
// falling clock edges. It then checks the device acknowledge and reports done
// or error.
//
// Ports:
//   clk_50m          in   system clock, all logic on its rising edge
//   rst              in   synchronous reset, active-high
//   tx_data[7:0]     in   byte to send, captured on acceptance
//   tx_valid         in   request to send tx_data
//   tx_ready         out  high in IDLE; accept = tx_valid & tx_ready
//   kclk_in          in   raw PS/2 clock pad (asynchronous)
//   kdata_in         in   raw PS/2 data pad (asynchronous)
//   kclk_drive_low   out  1 = pull kclk low
//   kdata_drive_low  out  1 = pull kdata low
//   busy             out  high whenever not IDLE (receive path must ignore lines)
//   tx_done          out  one-cycle pulse: byte acknowledged, lines idle again
//   tx_err           out  one-cycle pulse: transfer aborted
//   err_code[1:0]    out  abort cause, held until next tx_err
//                         01 start timeout, 10 bit/idle timeout, 11 no ack
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYC  = 5000,
    parameter int START_TO_CYC = 750000,
    parameter int XFER_TO_CYC  = 100000,
    parameter int FILT         = 8
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_drive_low,
    output logic       kdata_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int TMAX_A = (START_TO_CYC > XFER_TO_CYC) ? START_TO_CYC : XFER_TO_CYC;
    localparam int TMAX   = (TMAX_A > INHIBIT_CYC) ? TMAX_A : INHIBIT_CYC;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int FW     = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE
    } state_t;

    // Input conditioning: 2-flop synchronizer and stability filter per line
    logic [1:0]    r_kclk_sync;
    logic [1:0]    r_kdata_sync;
    logic [FW-1:0] r_kclk_cnt;
    logic [FW-1:0] r_kdata_cnt;
    logic          r_kclk_filt;
    logic          r_kdata_filt;
    logic          r_kclk_filt_d;
    logic          w_kclk_fe;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_kclk_sync   <= 2'b11;
            r_kdata_sync  <= 2'b11;
            r_kclk_cnt    <= '0;
            r_kdata_cnt   <= '0;
            r_kclk_filt   <= 1'b1;
            r_kdata_filt  <= 1'b1;
            r_kclk_filt_d <= 1'b1;
        end else begin
            r_kclk_sync   <= {r_kclk_sync[0], kclk_in};
            r_kdata_sync  <= {r_kdata_sync[0], kdata_in};
            r_kclk_filt_d <= r_kclk_filt;

            // The filtered value only moves after FILT consecutive samples
            // that disagree with it; any agreeing sample restarts the count.
            if (r_kclk_sync[1] == r_kclk_filt) begin
                r_kclk_cnt <= '0;
            end else if (r_kclk_cnt == FW'(FILT - 1)) begin
                r_kclk_filt <= r_kclk_sync[1];
                r_kclk_cnt  <= '0;
            end else begin
                r_kclk_cnt <= r_kclk_cnt + 1'b1;
            end

            if (r_kdata_sync[1] == r_kdata_filt) begin
                r_kdata_cnt <= '0;
            end else if (r_kdata_cnt == FW'(FILT - 1)) begin
                r_kdata_filt <= r_kdata_sync[1];
                r_kdata_cnt  <= '0;
            end else begin
                r_kdata_cnt <= r_kdata_cnt + 1'b1;
            end
        end
    end

    assign w_kclk_fe = r_kclk_filt_d & ~r_kclk_filt;

    // Transfer FSM
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic          r_seen_fe;
    logic          w_seen_nxt;
    logic          r_kdata_drv;
    logic          w_drv_nxt;
    logic [7:0]    r_byte;
    logic          r_parity;
    logic          w_load;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic [1:0]    r_err_code;
    logic [1:0]    w_code_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_idx_nxt   = r_idx;
        w_seen_nxt  = r_seen_fe;
        w_drv_nxt   = r_kdata_drv;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_INHIBIT;
                    w_timer_nxt = '0;
                end
            end

            S_INHIBIT: begin
                if (r_timer == TW'(INHIBIT_CYC - 1)) begin
                    w_state_nxt = S_REQ;
                    w_timer_nxt = '0;
                end
            end

            S_REQ: begin
                // Data stays low into SHIFT: that is the start bit.
                w_state_nxt = S_SHIFT;
                w_timer_nxt = '0;
                w_idx_nxt   = '0;
                w_seen_nxt  = 1'b0;
                w_drv_nxt   = 1'b1;
            end

            S_SHIFT: begin
                if (w_kclk_fe) begin
                    // Timer counts cycles since the last edge, so the edge
                    // cycle itself is cycle 0 and the next one is 1.
                    w_timer_nxt = TW'(1);
                    w_seen_nxt  = 1'b1;
                    if (r_idx < 4'd8) begin
                        w_drv_nxt = ~r_byte[r_idx[2:0]];
                        w_idx_nxt = r_idx + 4'd1;
                    end else if (r_idx == 4'd8) begin
                        w_drv_nxt = ~r_parity;
                        w_idx_nxt = r_idx + 4'd1;
                    end else if (r_idx == 4'd9) begin
                        w_drv_nxt = 1'b0;
                        w_idx_nxt = r_idx + 4'd1;
                    end else if (!r_kdata_filt) begin
                        w_state_nxt = S_WAIT_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = 2'b11;
                    end
                end else if (!r_seen_fe && r_timer == TW'(START_TO_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = 2'b01;
                end else if (r_seen_fe && r_timer == TW'(XFER_TO_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = 2'b10;
                end
            end

            S_WAIT_IDLE: begin
                if (r_kclk_filt && r_kdata_filt) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_timer == TW'(XFER_TO_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = 2'b10;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_seen_fe  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_idx      <= w_idx_nxt;
            r_seen_fe  <= w_seen_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_code_nxt;
        end
    end

    // Byte, parity and data-drive bit are only observed while their state is
    // active, so they need no reset.
    always_ff @(posedge clk_50m) begin
        if (w_load) begin
            r_byte   <= tx_data;
            r_parity <= ~^tx_data;
        end
        r_kdata_drv <= w_drv_nxt;
    end

    // Drive enables decode from the registered state, so leaving for IDLE
    // releases both lines on the same edge.
    assign tx_ready        = (r_state == S_IDLE);
    assign busy            = ~tx_ready;
    assign kclk_drive_low  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign kdata_drive_low = (r_state == S_REQ) || ((r_state == S_SHIFT) && r_kdata_drv);
    assign tx_done         = r_done;
    assign tx_err          = r_err;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INHIBIT  = 5000;
    localparam int START_TO = 1000;
    localparam int XFER_TO  = 500;
    localparam int FILT     = 8;
    localparam int HALF     = 40;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       kclk_in;
    logic       kdata_in;
    logic       kclk_drive_low;
    logic       kdata_drive_low;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    // Open-drain lines with pull-ups: low if either side pulls.
    assign kclk_in  = ~(kclk_drive_low | dev_clk_low);
    assign kdata_in = ~(kdata_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC (INHIBIT),
        .START_TO_CYC(START_TO),
        .XFER_TO_CYC (XFER_TO),
        .FILT        (FILT)
    ) dut (
        .clk_50m        (clk_50m),
        .rst            (rst),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .kclk_in        (kclk_in),
        .kdata_in       (kdata_in),
        .kclk_drive_low (kclk_drive_low),
        .kdata_drive_low(kdata_drive_low),
        .busy           (busy),
        .tx_done        (tx_done),
        .tx_err         (tx_err),
        .err_code       (err_code)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int   acc_count = 0;
    int   acc_cyc = -1;
    int   done_count = 0;
    int   done_cyc = -1;
    int   err_count = 0;
    int   err_cyc = -1;
    int   both_count = 0;
    logic [1:0] err_code_s = 2'b00;
    logic [1:0] err_drv_s = 2'b00;
    logic       done_busy_s = 1'b0;

    // Event recorder: sees values of the cycle that ends at this edge.
    always @(posedge clk_50m) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                acc_count++;
                acc_cyc = cyc;
            end
            if (tx_done) begin
                done_count++;
                done_cyc = cyc;
                done_busy_s = busy;
            end
            if (tx_err) begin
                err_count++;
                err_cyc = cyc;
                err_code_s = err_code;
                err_drv_s = {kclk_drive_low, kdata_drive_low};
            end
            if (tx_done && tx_err) both_count++;
        end
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, output int acc_c);
        tx_data  = d;
        tx_valid = 1'b1;
        acc_c    = -1;
        for (int k = 0; k < 100 && acc_c < 0; k++) begin
            if (tx_ready) acc_c = cyc;
            @(negedge clk_50m);
        end
        tx_valid = 1'b0;
        checks++;
        if (acc_c < 0) begin
            errors++;
            $display("FAIL send_accept: byte %h not accepted within 100 cycles", d);
        end
    endtask

    // Called on the cycle right after acceptance; returns the SHIFT entry cycle.
    task automatic measure_inhibit(input int acc_c, output int s_cyc);
        int lowcnt = 0;
        int dcnt = 0;
        int dlast = -1;
        checks++;
        if ({kclk_drive_low, tx_ready, busy} !== 3'b101 || cyc != acc_c + 1) begin
            errors++;
            $display("FAIL accept_latency: clk_low/ready/busy=%b at cycle %0d, required 101 at cycle %0d",
                     {kclk_drive_low, tx_ready, busy}, cyc, acc_c + 1);
        end
        while (kclk_drive_low === 1'b1 && lowcnt < INHIBIT + 100) begin
            lowcnt++;
            if (kdata_drive_low === 1'b1) begin
                dcnt++;
                dlast = cyc;
            end
            @(negedge clk_50m);
        end
        s_cyc = cyc;
        checks++;
        if (lowcnt != INHIBIT + 1) begin
            errors++;
            $display("FAIL kclk_low_len: got %0d cycles, required %0d", lowcnt, INHIBIT + 1);
        end
        checks++;
        if (dcnt != 1 || dlast != s_cyc - 1) begin
            errors++;
            $display("FAIL req_cycle: data low %0d cycles ending %0d, required 1 ending %0d",
                     dcnt, dlast, s_cyc - 1);
        end
        checks++;
        if (kdata_drive_low !== 1'b1) begin
            errors++;
            $display("FAIL start_bit: kdata_drive_low=%b at SHIFT entry, required 1", kdata_drive_low);
        end
    endtask

    // Device model: n clock pulses, data sampled at the end of each low half.
    task automatic dev_model(input int n, input bit ack, input bit glitch,
                             output logic [10:0] bits, output int last_fall);
        bits = '1;
        last_fall = -1;
        repeat (100) @(negedge clk_50m);
        for (int i = 0; i < n; i++) begin
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (20) @(negedge clk_50m);
            end
            dev_clk_low = 1'b1;
            last_fall = cyc;
            repeat (HALF) @(negedge clk_50m);
            bits[i] = kdata_in;
            dev_clk_low = 1'b0;
            if (glitch && i == 1) begin
                repeat (15) @(negedge clk_50m);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk_50m);
                dev_clk_low = 1'b0;
                repeat (HALF - 18) @(negedge clk_50m);
            end else begin
                repeat (HALF) @(negedge clk_50m);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic pop_exp(output logic [7:0] e);
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL scoreboard_depth: %0d entries, required 1", exp_q.size());
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 8'hxx;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_count == d0 && n < 400) begin
            @(negedge clk_50m);
            n++;
        end
    endtask

    task automatic wait_err(input int e0, input int bound);
        int n = 0;
        while (err_count == e0 && n < bound) begin
            @(negedge clk_50m);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50m);
            checks++;
            if ({kclk_drive_low, kdata_drive_low, tx_ready, busy, tx_done, tx_err, err_code} !== 8'b0010_0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b, required 00100000",
                         {kclk_drive_low, kdata_drive_low, tx_ready, busy, tx_done, tx_err, err_code});
            end
            tx_data      = 8'($urandom);
            tx_valid     = 1'($urandom_range(0, 1));
            dev_clk_low  = 1'($urandom_range(0, 1));
            dev_data_low = 1'($urandom_range(0, 1));
        end
        @(negedge clk_50m);
        rst = 1'b0;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (30) @(negedge clk_50m);
        checks++;
        if ({kclk_drive_low, kdata_drive_low, tx_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, required 0010",
                     {kclk_drive_low, kdata_drive_low, tx_ready, busy});
        end
    endtask

    task automatic test_send_ack();
        int acc, s, lf, a0, d0, e0;
        logic [10:0] bits;
        logic [7:0] e;
        send(8'hED, acc);
        measure_inhibit(acc, s);
        a0 = acc_count;
        tx_data = 8'h55;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk_50m);
        tx_valid = 1'b0;
        checks++;
        if (acc_count != a0) begin
            errors++;
            $display("FAIL valid_while_busy: accepts %0d, required %0d", acc_count, a0);
        end
        d0 = done_count;
        e0 = err_count;
        dev_model(11, 1'b1, 1'b0, bits, lf);
        pop_exp(e);
        checks++;
        if (bits[9:0] !== {1'b1, ~^e, e}) begin
            errors++;
            $display("FAIL ack_frame: device saw %b, required %b", bits[9:0], {1'b1, ~^e, e});
        end
        wait_done(d0);
        repeat (20) @(negedge clk_50m);
        checks++;
        if (done_count != d0 + 1 || err_count != e0 || both_count != 0) begin
            errors++;
            $display("FAIL ack_result: done %0d err %0d both %0d, required done %0d err %0d both 0",
                     done_count - d0, err_count - e0, both_count, 1, 0);
        end
        checks++;
        if (done_busy_s !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: busy=%b in tx_done cycle, required 0", done_busy_s);
        end
    endtask

    task automatic test_no_ack();
        int acc, s, lf, d0, e0;
        logic [10:0] bits;
        logic [7:0] e;
        send(8'h07, acc);
        measure_inhibit(acc, s);
        d0 = done_count;
        e0 = err_count;
        dev_model(11, 1'b0, 1'b0, bits, lf);
        wait_err(e0, 200);
        pop_exp(e);
        checks++;
        if (bits[9:0] !== {1'b1, ~^e, e}) begin
            errors++;
            $display("FAIL noack_frame: device saw %b, required %b", bits[9:0], {1'b1, ~^e, e});
        end
        checks++;
        if (err_count != e0 + 1 || err_code_s !== 2'b11 || err_drv_s !== 2'b00 || done_count != d0) begin
            errors++;
            $display("FAIL noack_err: errs %0d code %b drv %b dones %0d, required 1 11 00 0",
                     err_count - e0, err_code_s, err_drv_s, done_count - d0);
        end
        checks++;
        if (err_cyc != lf + FILT + 3) begin
            errors++;
            $display("FAIL noack_latency: tx_err at cycle %0d, required %0d", err_cyc, lf + FILT + 3);
        end
    endtask

    task automatic test_start_timeout();
        int acc, s, e0;
        logic [7:0] e;
        send(8'h3C, acc);
        measure_inhibit(acc, s);
        e0 = err_count;
        wait_err(e0, START_TO + 200);
        pop_exp(e);
        checks++;
        if (err_count != e0 + 1 || err_cyc != s + START_TO) begin
            errors++;
            $display("FAIL start_to_time: errs %0d at cycle %0d, required 1 at %0d",
                     err_count - e0, err_cyc, s + START_TO);
        end
        checks++;
        if (err_code_s !== 2'b01 || err_drv_s !== 2'b00) begin
            errors++;
            $display("FAIL start_to_code: code %b drv %b, required 01 00", err_code_s, err_drv_s);
        end
    endtask

    task automatic test_xfer_timeout();
        int acc, s, lf, e0;
        logic [10:0] bits;
        logic [7:0] e;
        send(8'h08, acc);
        measure_inhibit(acc, s);
        e0 = err_count;
        dev_model(4, 1'b0, 1'b1, bits, lf);
        wait_err(e0, XFER_TO + 200);
        pop_exp(e);
        checks++;
        if (bits[3:0] !== e[3:0]) begin
            errors++;
            $display("FAIL glitch_bits: device saw %b, required %b", bits[3:0], e[3:0]);
        end
        checks++;
        if (err_count != e0 + 1 || err_cyc != lf + FILT + 2 + XFER_TO) begin
            errors++;
            $display("FAIL xfer_to_time: errs %0d at cycle %0d, required 1 at %0d",
                     err_count - e0, err_cyc, lf + FILT + 2 + XFER_TO);
        end
        checks++;
        if (err_code_s !== 2'b10 || err_drv_s !== 2'b00) begin
            errors++;
            $display("FAIL xfer_to_code: code %b drv %b, required 10 00", err_code_s, err_drv_s);
        end
    endtask

    task automatic test_reset_mid();
        int acc, s, lf, d0, e0;
        logic [10:0] bits;
        logic [7:0] e;
        send(8'hA1, acc);
        measure_inhibit(acc, s);
        d0 = done_count;
        e0 = err_count;
        dev_model(3, 1'b0, 1'b0, bits, lf);
        checks++;
        if (kdata_drive_low !== 1'b1) begin
            errors++;
            $display("FAIL mid_drive: kdata_drive_low=%b at index 3, required 1", kdata_drive_low);
        end
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        checks++;
        if ({kclk_drive_low, kdata_drive_low, tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset: drives/ready=%b, required 001",
                     {kclk_drive_low, kdata_drive_low, tx_ready});
        end
        repeat (XFER_TO + 100) @(negedge clk_50m);
        pop_exp(e);
        checks++;
        if (bits[2:0] !== e[2:0]) begin
            errors++;
            $display("FAIL mid_bits: device saw %b, required %b", bits[2:0], e[2:0]);
        end
        checks++;
        if (done_count != d0 || err_count != e0) begin
            errors++;
            $display("FAIL mid_no_pulse: dones %0d errs %0d, required 0 0",
                     done_count - d0, err_count - e0);
        end
    endtask

    task automatic test_back_to_back();
        int acc, s, lf, d0, a0;
        logic [10:0] bits;
        logic [7:0] e;
        a0 = acc_count;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 100 && acc < 0; k++) begin
            if (tx_ready) acc = cyc;
            @(negedge clk_50m);
        end
        tx_data = 8'h00;
        measure_inhibit(acc, s);
        d0 = done_count;
        dev_model(11, 1'b1, 1'b0, bits, lf);
        pop_exp(e);
        checks++;
        if (bits[9:0] !== {1'b1, ~^e, e} || bits[8] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame1: device saw %b, required %b", bits[9:0], {1'b1, ~^e, e});
        end
        wait_done(d0);
        tx_valid = 1'b0;
        checks++;
        if (done_count != d0 + 1 || acc_count != a0 + 2 || acc_cyc != done_cyc) begin
            errors++;
            $display("FAIL b2b_accept: dones %0d accepts %0d accept cycle %0d, required 1 2 at %0d",
                     done_count - d0, acc_count - a0, acc_cyc, done_cyc);
        end
        measure_inhibit(acc_cyc, s);
        d0 = done_count;
        dev_model(11, 1'b1, 1'b0, bits, lf);
        pop_exp(e);
        checks++;
        if (bits[9:0] !== {1'b1, ~^e, e} || bits[8] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame2: device saw %b, required %b", bits[9:0], {1'b1, ~^e, e});
        end
        wait_done(d0);
        repeat (20) @(negedge clk_50m);
        checks++;
        if (done_count != d0 + 1 || both_count != 0) begin
            errors++;
            $display("FAIL b2b_done2: dones %0d both %0d, required 1 0", done_count - d0, both_count);
        end
    endtask

    initial begin
        test_reset();
        test_send_ack();
        test_no_ack();
        test_start_timeout();
        test_xfer_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
